// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: PC source encoding,
// the canonical NOP and the entry format handed to decode.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_BR  = 2'b01,
    PC_JAL = 2'b10
  } pc_source_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  // Only the two named redirect encodings redirect; 2'b11 behaves like PC_INC.
  function automatic logic is_redirect(input logic [1:0] src);
    return (src == PC_BR) || (src == PC_JAL);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a single-cycle flush. Push and pop in the same
// cycle are both honoured, including when the FIFO is full.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_MAX);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // Storage needs no reset; only entries covered by count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the fetch PC, issues in-order requests
// to instruction memory under a credit limit, pairs responses with their PCs
// and buffers them for decode. Redirects flush buffered work and drop any
// responses still in flight for the old path.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_source,
  input  logic [31:0] br_target,
  input  logic [31:0] jal_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic          halted;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic          fault_pending;
  logic [31:0]   fault_pc;

  logic          redirect;
  logic [31:0]   target;
  logic          req_fire;
  logic          pop_fire;
  logic [CW:0]   in_use;
  logic [CW-1:0] req_inc;
  logic [CW-1:0] rsp_dec;

  logic [31:0]   pcq_head;
  logic          pcq_empty;
  logic          pcq_full;
  logic [CW-1:0] pcq_count;

  logic          out_push;
  fetch_entry_t  out_data;
  fetch_entry_t  out_head;
  logic          out_empty;
  logic          out_full;
  logic [CW-1:0] out_count;

  assign redirect = is_redirect(pc_source);
  assign target   = (pc_source == PC_JAL) ? jal_target : br_target;

  assign if_valid = !out_empty;
  assign if_instr = out_head.instr;
  assign if_pc    = out_head.pc;
  assign if_fault = out_head.fault;
  assign pop_fire = if_valid && if_ready && !redirect;

  // An entry leaving this cycle frees its credit immediately, which is what
  // lets a short-latency memory sustain one instruction per cycle.
  assign in_use = {1'b0, outstanding} + {1'b0, out_count} - {{CW{1'b0}}, pop_fire};

  assign imem_req_valid = !rst && !halted && !redirect && (in_use < DEPTH_L);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign req_inc        = {{(CW-1){1'b0}}, req_fire};
  assign rsp_dec        = {{(CW-1){1'b0}}, imem_rsp_valid};

  // PCs of accepted requests, popped in order as responses come back
  // (including responses that are being dropped).
  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (imem_rsp_valid),
    .head_data (pcq_head),
    .empty     (pcq_empty),
    .full      (pcq_full),
    .count     (pcq_count)
  );

  // Instructions waiting for decode; cleared wholesale on a redirect.
  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (out_push),
    .push_data (out_data),
    .pop       (pop_fire),
    .head_data (out_head),
    .empty     (out_empty),
    .full      (out_full),
    .count     (out_count)
  );

  // Choose what enters the output FIFO: a pending misalignment marker wins,
  // otherwise a response that is not being dropped.
  always_comb begin
    out_push = 1'b0;
    out_data = '0;
    if (!redirect) begin
      if (fault_pending) begin
        out_push = 1'b1;
        out_data = '{pc: fault_pc, instr: NOP_INSTR, fault: 1'b1};
      end else if (imem_rsp_valid && (drop_cnt == '0)) begin
        out_push = 1'b1;
        out_data = '{pc: pcq_head, instr: imem_rsp_data, fault: 1'b0};
      end
    end
  end

  // Fetch PC, credit counters and redirect handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc      <= RESET_PC;
      halted        <= 1'b0;
      outstanding   <= '0;
      drop_cnt      <= '0;
      fault_pending <= 1'b0;
      fault_pc      <= '0;
    end else begin
      fault_pending <= 1'b0;
      if (redirect) begin
        outstanding <= outstanding - rsp_dec;
        drop_cnt    <= outstanding - rsp_dec;
        if (target[1:0] == 2'b00) begin
          fetch_pc <= target;
          halted   <= 1'b0;
        end else begin
          halted        <= 1'b1;
          fault_pending <= 1'b1;
          fault_pc      <= target;
        end
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        outstanding <= outstanding + req_inc - rsp_dec;
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - ONE;
      end
    end
  end

  a_no_reserved_src: assert property (@(posedge clk) disable iff (rst)
    pc_source != 2'b11);
  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (outstanding == '0)));
  a_rsp_has_pc: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && pcq_empty));
  a_credit_limit: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, outstanding} + {1'b0, out_count}) <= DEPTH_L);
  a_pcq_tracks: assert property (@(posedge clk) disable iff (rst)
    pcq_count == outstanding);
  a_pcq_room: assert property (@(posedge clk) disable iff (rst)
    !(req_fire && pcq_full));
  a_out_room: assert property (@(posedge clk) disable iff (rst)
    !(out_push && out_full && !pop_fire));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order memory model with adjustable latency,
// directed stimulus that queues expected deliveries, and an independent
// monitor that scores every decode handshake against that queue.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_source;
  logic [31:0] br_target;
  logic [31:0] jal_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_source      (pc_source),
    .br_target      (br_target),
    .jal_target     (jal_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_fault       (if_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  int          deliv_cyc[$];
  int          deliv_cnt = 0;
  mreq_t       mem_q[$];
  int          mem_lat = 1;
  logic [31:0] mem_rsp_addr = '0;

  // Memory contents: every word is a recognisable function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 + a;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expectEntry(input logic [31:0] pc, input logic fault);
    exp_t e;
    e.pc    = pc;
    e.instr = fault ? NOP_INSTR : mem_word(pc);
    e.fault = fault;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] src, input logic [31:0] tgt, input logic rdy);
    pc_source  = src;
    br_target  = (src == PC_JAL) ? 32'hDEAD_0000 : tgt;
    jal_target = (src == PC_JAL) ? tgt : 32'hBEEF_0000;
    if_ready   = rdy;
  endtask

  // Hold reset for two cycles, check outputs are quiet, then release and
  // confirm the very first request targets the reset PC.
  task automatic resetDut(input logic rdy);
    step();
    rst = 1'b1;
    applyStimulus(PC_INC, 32'h0, 1'b0);
    step();
    step();
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
    exp_q.delete();
    req_log.delete();
    deliv_cyc.delete();
    deliv_cnt = 0;
    step();
    rst = 1'b0;
    if_ready = rdy;
    #1;
    checkOutput("first_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("first_req_addr", imem_req_addr, 32'h0000_0000);
  endtask

  // In-order memory: responds mem_lat cycles after accepting a request.
  always begin
    @(negedge clk);
    if (rst) begin
      mem_q.delete();
      imem_rsp_valid = 1'b0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      mem_rsp_addr   = mem_q[0].addr;
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
    #4;
    if (!rst && imem_req_valid && imem_req_ready) begin
      mem_q.push_back('{imem_req_addr, cyc + mem_lat});
      req_log.push_back(imem_req_addr);
    end
  end

  // Monitor: every accepted decode handshake is scored against the queue.
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    if (!rst && if_valid && if_ready && !(pc_source == PC_BR || pc_source == PC_JAL)) begin
      deliv_cyc.push_back(cyc);
      deliv_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL unexpected_delivery: got pc %h, required no delivery", if_pc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("if_pc", if_pc, e.pc);
        checkOutput("if_instr", if_instr, e.instr);
        checkOutput("if_fault", 32'(if_fault), 32'(e.fault));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    pc_source      = PC_INC;
    br_target      = '0;
    jal_target     = '0;
    if_ready       = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;

    // Streaming with latency 1: sequential PCs at one per cycle.
    $display("[TB] streaming, latency 1");
    mem_lat = 1;
    resetDut(1'b1);
    for (int k = 0; k < 6; k++) expectEntry(32'(4 * k), 1'b0);
    for (int i = 0; i < 50 && deliv_cnt < 6; i++) step();
    if_ready = 1'b0;
    checkOutput("t1_delivered", 32'(deliv_cnt), 32'd6);
    checkOutput("t1_req1", req_log.size() > 1 ? req_log[1] : 32'hFFFF_FFFF, 32'h4);
    checkOutput("t1_req3", req_log.size() > 3 ? req_log[3] : 32'hFFFF_FFFF, 32'hC);
    checkOutput("t1_throughput", deliv_cyc.size() > 5 ? 32'(deliv_cyc[5] - deliv_cyc[2]) : 32'hFFFF_FFFF, 32'd3);

    // Decode stalled: only DEPTH requests go out, then fetch resumes.
    $display("[TB] decode stall");
    mem_lat = 1;
    resetDut(1'b0);
    for (int i = 0; i < 8; i++) step();
    checkOutput("t2_req_count", 32'(req_log.size()), 32'd2);
    checkOutput("t2_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("t2_if_valid", 32'(if_valid), 32'd1);
    for (int k = 0; k < 4; k++) expectEntry(32'(4 * k), 1'b0);
    applyStimulus(PC_INC, 32'h0, 1'b1);
    for (int i = 0; i < 30 && deliv_cnt < 4; i++) step();
    if_ready = 1'b0;
    checkOutput("t2_delivered", 32'(deliv_cnt), 32'd4);
    checkOutput("t2_req2", req_log.size() > 2 ? req_log[2] : 32'hFFFF_FFFF, 32'h8);

    // Branch with two requests in flight: both responses are discarded.
    $display("[TB] branch with two in flight");
    mem_lat = 3;
    resetDut(1'b1);
    expectEntry(32'h0, 1'b0);
    expectEntry(32'h4, 1'b0);
    expectEntry(32'h100, 1'b0);
    expectEntry(32'h104, 1'b0);
    for (int i = 0; i < 50 && !(req_log.size() == 4 && mem_q.size() == 2 && !imem_rsp_valid && !if_valid); i++) step();
    checkOutput("t3_setup", 32'(req_log.size() == 4 && mem_q.size() == 2), 32'd1);
    applyStimulus(PC_BR, 32'h100, 1'b1);
    #1;
    checkOutput("t3_redirect_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    applyStimulus(PC_INC, 32'h0, 1'b1);
    for (int i = 0; i < 60 && deliv_cnt < 4; i++) step();
    if_ready = 1'b0;
    checkOutput("t3_delivered", 32'(deliv_cnt), 32'd4);
    checkOutput("t3_req_after", req_log.size() > 4 ? req_log[4] : 32'hFFFF_FFFF, 32'h100);

    // Jump in the same cycle the response for address 4 returns.
    $display("[TB] jump coinciding with a response");
    mem_lat = 1;
    resetDut(1'b1);
    expectEntry(32'h0, 1'b0);
    expectEntry(32'h40, 1'b0);
    expectEntry(32'h44, 1'b0);
    for (int i = 0; i < 10 && req_log.size() < 1; i++) step();
    mem_lat = 4;
    for (int i = 0; i < 30 && !(imem_rsp_valid && mem_rsp_addr == 32'h4); i++) step();
    checkOutput("t4_rsp4_seen", 32'(imem_rsp_valid && mem_rsp_addr == 32'h4), 32'd1);
    checkOutput("t4_in_flight", 32'(mem_q.size()), 32'd1);
    applyStimulus(PC_JAL, 32'h40, 1'b1);
    #1;
    checkOutput("t4_redirect_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    applyStimulus(PC_INC, 32'h0, 1'b1);
    for (int i = 0; i < 60 && deliv_cnt < 3; i++) step();
    if_ready = 1'b0;
    checkOutput("t4_delivered", 32'(deliv_cnt), 32'd3);
    checkOutput("t4_req_after", req_log.size() > 3 ? req_log[3] : 32'hFFFF_FFFF, 32'h40);

    // Misaligned branch: one fault marker, fetch halts until an aligned jump.
    $display("[TB] misaligned branch");
    mem_lat = 1;
    resetDut(1'b0);
    for (int i = 0; i < 6; i++) step();
    expectEntry(32'h102, 1'b1);
    applyStimulus(PC_BR, 32'h102, 1'b1);
    step();
    applyStimulus(PC_INC, 32'h0, 1'b1);
    for (int i = 0; i < 10 && deliv_cnt < 1; i++) step();
    for (int i = 0; i < 10; i++) step();
    checkOutput("t5_delivered", 32'(deliv_cnt), 32'd1);
    checkOutput("t5_halted_reqs", 32'(req_log.size()), 32'd2);
    checkOutput("t5_halted_req_valid", 32'(imem_req_valid), 32'd0);
    expectEntry(32'h200, 1'b0);
    expectEntry(32'h204, 1'b0);
    applyStimulus(PC_JAL, 32'h200, 1'b1);
    step();
    applyStimulus(PC_INC, 32'h0, 1'b1);
    for (int i = 0; i < 30 && deliv_cnt < 3; i++) step();
    if_ready = 1'b0;
    checkOutput("t5_resumed", 32'(deliv_cnt), 32'd3);
    checkOutput("t5_req_after", req_log.size() > 2 ? req_log[2] : 32'hFFFF_FFFF, 32'h200);

    // Reset in the middle of streaming: outputs drop without a clock edge.
    $display("[TB] reset mid-stream");
    mem_lat = 1;
    resetDut(1'b1);
    expectEntry(32'h0, 1'b0);
    expectEntry(32'h4, 1'b0);
    for (int i = 0; i < 30 && deliv_cnt < 2; i++) step();
    checkOutput("t6_busy", 32'(if_valid && imem_req_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6_if_valid_drop", 32'(if_valid), 32'd0);
    checkOutput("t6_req_valid_drop", 32'(imem_req_valid), 32'd0);
    if_ready = 1'b0;
    resetDut(1'b0);
    step();
    checkOutput("t6_first_req", req_log.size() > 0 ? req_log[0] : 32'hFFFF_FFFF, 32'h0);

    checkOutput("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
